counter_4b_seq: RTL and testbench



---
 rtl/counter_4b_pkg.sv | 35 +++
 rtl/cmd_fifo_sync.sv | 45 ++++
 rtl/counter_4b_seq.sv | 153 +++++++++++++++
 tb/tb_counter_4b_seq.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_4b_pkg.sv
// rtl/counter_4b_pkg.sv - shared mode constants, FSM encoding and command record for the counter sequencer
package counter_4b_pkg;

  localparam logic [1:0] MODE_UP3  = 2'b00;
  localparam logic [1:0] MODE_DN1  = 2'b01;
  localparam logic [1:0] MODE_UP1  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RUN,
    ST_LOADWAIT
  } seq_state_e;

  // Command word in the FIFO is {hdr, count}; count width is set by the top.
  typedef struct packed {
    logic [1:0] mode;
    logic [3:0] data;
  } cmd_hdr_t;

  localparam int HDR_W = $bits(cmd_hdr_t);

  function automatic logic is_count_mode(input logic [1:0] m);
    logic r;
    r = 1'b0;
    unique case (m)
      MODE_UP3, MODE_DN1, MODE_UP1: r = 1'b1;
      MODE_LOAD:                    r = 1'b0;
      default:                      r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cmd_fifo_sync.sv
// rtl/cmd_fifo_sync.sv - synchronous command FIFO with wrap-bit pointers
module cmd_fifo_sync #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  // A simultaneous pop never frees room for a push in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/counter_4b_seq.sv
// rtl/counter_4b_seq.sv - command sequencer driving the 4-bit counter from a buffered command queue
module counter_4b_seq
  import counter_4b_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [3:0]       cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             ctr_enable,
  output logic [1:0]       ctr_mode,
  output logic [3:0]       ctr_D,
  input  logic             ctr_rco,
  input  logic             ctr_load,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int              TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [HDR_W+CNT_W-1:0] fifo_rdata;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop;
  cmd_hdr_t               rd_hdr;
  logic [CNT_W-1:0]       rd_count;

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [1:0]       mode_q, mode_d;
  logic [3:0]       data_q, data_d;
  logic             en_q;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             finish;

  cmd_fifo_sync #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (HDR_W + CNT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_valid),
    .wdata ({cmd_mode, cmd_data, cmd_count}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rd_hdr   = cmd_hdr_t'(fifo_rdata[CNT_W +: HDR_W]);
  assign rd_count = fifo_rdata[CNT_W-1:0];

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    timer_d     = timer_q;
    mode_d      = mode_q;
    data_d      = data_q;
    err_d       = err_q;
    done_d      = 1'b0;
    pop         = 1'b0;
    finish      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          mode_d      = rd_hdr.mode;
          data_d      = rd_hdr.data;
          remaining_d = rd_count;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!is_count_mode(mode_q)) begin
          state_d = ST_LOADWAIT;
          timer_d = '0;
        end else if (remaining_q == '0) begin
          finish = 1'b1;
        end else begin
          state_d = ST_RUN;
          if (ctr_rco) begin
            if (remaining_q == ONE) finish = 1'b1;
            else                    remaining_d = remaining_q - 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (ctr_rco) begin
          if (remaining_q == ONE) finish = 1'b1;
          else                    remaining_d = remaining_q - 1'b1;
        end
      end
      ST_LOADWAIT: begin
        if (ctr_load) begin
          finish = 1'b1;
        end else if (timer_q == TMO_LAST) begin
          finish = 1'b1;
          err_d  = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Completion always lands in IDLE, so done marks the first IDLE cycle.
    if (finish) begin
      state_d = ST_IDLE;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      timer_q     <= '0;
      mode_q      <= MODE_UP3;
      data_q      <= '0;
      en_q        <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      timer_q     <= timer_d;
      mode_q      <= mode_d;
      data_q      <= data_d;
      en_q        <= (state_d != ST_IDLE);
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign ctr_enable = en_q;
  assign ctr_mode   = mode_q;
  assign ctr_D      = data_q;
  assign done       = done_q;
  assign err        = err_q;
  assign cmd_ready  = !fifo_full;
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_counter_4b_seq.sv
// tb/tb_counter_4b_seq.sv - scoreboard bench for the counter command sequencer
module tb_counter_4b_seq;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_mode;
  logic [3:0]       cmd_data;
  logic [CNT_W-1:0] cmd_count;
  logic             ctr_enable;
  logic [1:0]       ctr_mode;
  logic [3:0]       ctr_D;
  logic             ctr_rco;
  logic             ctr_load;
  logic             busy;
  logic             done;
  logic             err;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [5:0] sb [$];
  logic [5:0] exp_cmd;

  always #5 clk = ~clk;

  counter_4b_seq #(
    .FIFO_DEPTH (4),
    .CNT_W      (CNT_W),
    .TIMEOUT    (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_mode   (cmd_mode),
    .cmd_data   (cmd_data),
    .cmd_count  (cmd_count),
    .ctr_enable (ctr_enable),
    .ctr_mode   (ctr_mode),
    .ctr_D      (ctr_D),
    .ctr_rco    (ctr_rco),
    .ctr_load   (ctr_load),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [1:0] m, input logic [3:0] d, input logic [CNT_W-1:0] c);
    cmd_valid = 1'b1;
    cmd_mode  = m;
    cmd_data  = d;
    cmd_count = c;
  endtask

  task automatic test_reset();
    reset = 1'b0; cmd_valid = 1'b0; cmd_mode = 2'b00; cmd_data = 4'h0;
    cmd_count = '0; ctr_rco = 1'b0; ctr_load = 1'b0;
    cyc(2);
    n_cmp++;
    if ({ctr_enable, ctr_mode, ctr_D, done, err, busy, cmd_ready} !== 11'b0_00_0000_0001) begin
      n_bad++;
      $display("FAIL rst_values: got %b want %b", {ctr_enable, ctr_mode, ctr_D, done, err, busy, cmd_ready}, 11'b0_00_0000_0001);
    end
    reset = 1'b1;
    cyc(3);
    n_cmp++;
    if ({ctr_enable, ctr_mode, ctr_D, done, err, busy, cmd_ready} !== 11'b0_00_0000_0001) begin
      n_bad++;
      $display("FAIL rst_release_idle: got %b want %b", {ctr_enable, ctr_mode, ctr_D, done, err, busy, cmd_ready}, 11'b0_00_0000_0001);
    end
  endtask

  task automatic test_load();
    drive_cmd(2'b11, 4'hA, '0);
    cyc(1);
    sb.push_back({2'b11, 4'hA});
    cmd_valid = 1'b0;
    n_cmp++;
    if (ctr_enable !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL load_push_cycle: got en=%b busy=%b want en=0 busy=1", ctr_enable, busy);
    end
    cyc(1);
    if (sb.size() != 0) exp_cmd = sb.pop_front(); else exp_cmd = 'x;
    n_cmp++;
    if (ctr_enable !== 1'b1 || {ctr_mode, ctr_D} !== exp_cmd) begin
      n_bad++;
      $display("FAIL load_issue: got en=%b cmd=%h want en=1 cmd=%h", ctr_enable, {ctr_mode, ctr_D}, exp_cmd);
    end
    cyc(2);
    ctr_load = 1'b1;
    cyc(1);
    ctr_load = 1'b0;
    n_cmp++;
    if ({done, ctr_enable, err} !== 3'b100) begin
      n_bad++;
      $display("FAIL load_done: got done/en/err=%b want 100", {done, ctr_enable, err});
    end
    cyc(1);
    n_cmp++;
    if ({done, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL load_after: got done/busy=%b want 00", {done, busy});
    end
  endtask

  task automatic test_count();
    bit ok;
    drive_cmd(2'b10, 4'h3, 8'd3);
    cyc(1);
    sb.push_back({2'b10, 4'h3});
    cmd_valid = 1'b0;
    cyc(1);
    if (sb.size() != 0) exp_cmd = sb.pop_front(); else exp_cmd = 'x;
    n_cmp++;
    if (ctr_enable !== 1'b1 || {ctr_mode, ctr_D} !== exp_cmd) begin
      n_bad++;
      $display("FAIL count_issue: got en=%b cmd=%h want en=1 cmd=%h", ctr_enable, {ctr_mode, ctr_D}, exp_cmd);
    end
    ok = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      ctr_rco = (k % 16 == 0);
      cyc(1);
      ctr_rco = 1'b0;
      if (k < 48 && (ctr_enable !== 1'b1 || done !== 1'b0)) ok = 1'b0;
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL count_hold: got early drop of enable want enable=1 until 3rd rco");
    end
    n_cmp++;
    if ({done, ctr_enable} !== 2'b10) begin
      n_bad++;
      $display("FAIL count_done: got done/en=%b want 10", {done, ctr_enable});
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] b [5];
    bit ok, ok_rdy, acc, b5_pending;
    int dcnt;
    b[0] = {2'b01, 4'h1}; b[1] = {2'b10, 4'h2}; b[2] = {2'b00, 4'h3};
    b[3] = {2'b01, 4'h4}; b[4] = {2'b10, 4'h5};
    drive_cmd(2'b00, 4'h7, 8'd2);
    cyc(1);
    sb.push_back({2'b00, 4'h7});
    cmd_valid = 1'b0;
    cyc(1);
    if (sb.size() != 0) exp_cmd = sb.pop_front(); else exp_cmd = 'x;
    n_cmp++;
    if ({ctr_mode, ctr_D} !== exp_cmd) begin
      n_bad++;
      $display("FAIL b2b_first_issue: got %h want %h", {ctr_mode, ctr_D}, exp_cmd);
    end
    cyc(1);
    ok_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (cmd_ready !== 1'b1) ok_rdy = 1'b0;
      drive_cmd(b[i][5:4], b[i][3:0], '0);
      cyc(1);
      sb.push_back(b[i]);
    end
    n_cmp++;
    if (!ok_rdy || cmd_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_ready_full: got ready_ok=%b ready=%b want 1 and 0", ok_rdy, cmd_ready);
    end
    drive_cmd(b[4][5:4], b[4][3:0], '0);
    cyc(3);
    n_cmp++;
    if ({cmd_ready, ctr_enable} !== 2'b01) begin
      n_bad++;
      $display("FAIL b2b_fifth_waits: got ready/en=%b want 01", {cmd_ready, ctr_enable});
    end
    ctr_rco = 1'b1;
    cyc(2);
    ctr_rco = 1'b0;
    n_cmp++;
    if ({done, ctr_enable} !== 2'b10) begin
      n_bad++;
      $display("FAIL b2b_first_done: got done/en=%b want 10", {done, ctr_enable});
    end
    dcnt = (done === 1'b1) ? 1 : 0;
    ok = 1'b1;
    b5_pending = 1'b1;
    for (int j = 0; j < 5; j++) begin
      acc = cmd_valid && cmd_ready;
      cyc(1);
      if (acc) begin sb.push_back(b[4]); cmd_valid = 1'b0; b5_pending = 1'b0; end
      if (ctr_enable !== 1'b1 || done !== 1'b0) ok = 1'b0;
      if (sb.size() != 0) exp_cmd = sb.pop_front(); else exp_cmd = 'x;
      n_cmp++;
      if ({ctr_mode, ctr_D} !== exp_cmd) begin
        n_bad++;
        $display("FAIL b2b_order[%0d]: got %h want %h", j, {ctr_mode, ctr_D}, exp_cmd);
      end
      acc = cmd_valid && cmd_ready;
      cyc(1);
      if (acc) begin sb.push_back(b[4]); cmd_valid = 1'b0; b5_pending = 1'b0; end
      if (ctr_enable !== 1'b0 || done !== 1'b1) ok = 1'b0;
      if (done === 1'b1) dcnt++;
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL b2b_gap: got enable/done pattern broken want 1-cycle idle between commands");
    end
    n_cmp++;
    if (dcnt != 6 || b5_pending || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_totals: got done=%0d pending=%b busy=%b want 6 0 0", dcnt, b5_pending, busy);
    end
  endtask

  task automatic test_timeout();
    drive_cmd(2'b11, 4'h5, '0);
    cyc(1);
    sb.push_back({2'b11, 4'h5});
    drive_cmd(2'b01, 4'h3, '0);
    cyc(1);
    sb.push_back({2'b01, 4'h3});
    cmd_valid = 1'b0;
    if (sb.size() != 0) exp_cmd = sb.pop_front(); else exp_cmd = 'x;
    n_cmp++;
    if ({ctr_mode, ctr_D} !== exp_cmd) begin
      n_bad++;
      $display("FAIL tmo_issue: got %h want %h", {ctr_mode, ctr_D}, exp_cmd);
    end
    cyc(16);
    n_cmp++;
    if ({err, ctr_enable, done} !== 3'b010) begin
      n_bad++;
      $display("FAIL tmo_before: got err/en/done=%b want 010", {err, ctr_enable, done});
    end
    cyc(1);
    n_cmp++;
    if ({err, ctr_enable, done} !== 3'b101) begin
      n_bad++;
      $display("FAIL tmo_expire: got err/en/done=%b want 101", {err, ctr_enable, done});
    end
    cyc(1);
    if (sb.size() != 0) exp_cmd = sb.pop_front(); else exp_cmd = 'x;
    n_cmp++;
    if (ctr_enable !== 1'b1 || {ctr_mode, ctr_D} !== exp_cmd) begin
      n_bad++;
      $display("FAIL tmo_next_issue: got en=%b cmd=%h want en=1 cmd=%h", ctr_enable, {ctr_mode, ctr_D}, exp_cmd);
    end
    cyc(1);
    n_cmp++;
    if ({err, ctr_enable, done} !== 3'b101) begin
      n_bad++;
      $display("FAIL tmo_next_done: got err/en/done=%b want 101", {err, ctr_enable, done});
    end
    cyc(1);
    n_cmp++;
    if ({err, busy} !== 2'b10) begin
      n_bad++;
      $display("FAIL tmo_sticky: got err/busy=%b want 10", {err, busy});
    end
  endtask

  task automatic test_rco_issue();
    drive_cmd(2'b10, 4'h6, 8'd1);
    cyc(1);
    sb.push_back({2'b10, 4'h6});
    drive_cmd(2'b00, 4'hC, 8'd2);
    cyc(1);
    sb.push_back({2'b00, 4'hC});
    cmd_valid = 1'b0;
    if (sb.size() != 0) exp_cmd = sb.pop_front(); else exp_cmd = 'x;
    n_cmp++;
    if ({ctr_mode, ctr_D} !== exp_cmd) begin
      n_bad++;
      $display("FAIL rco_issue_cmd: got %h want %h", {ctr_mode, ctr_D}, exp_cmd);
    end
    ctr_rco = 1'b1;
    cyc(1);
    ctr_rco = 1'b0;
    n_cmp++;
    if ({done, ctr_enable} !== 2'b10) begin
      n_bad++;
      $display("FAIL rco_issue_done: got done/en=%b want 10", {done, ctr_enable});
    end
    cyc(1);
    if (sb.size() != 0) exp_cmd = sb.pop_front(); else exp_cmd = 'x;
    n_cmp++;
    if (ctr_enable !== 1'b1 || {ctr_mode, ctr_D} !== exp_cmd) begin
      n_bad++;
      $display("FAIL rco_next_issue: got en=%b cmd=%h want en=1 cmd=%h", ctr_enable, {ctr_mode, ctr_D}, exp_cmd);
    end
    ctr_rco = 1'b1;
    cyc(1);
    n_cmp++;
    if ({done, ctr_enable} !== 2'b01) begin
      n_bad++;
      $display("FAIL rco_no_leftover: got done/en=%b want 01", {done, ctr_enable});
    end
    cyc(1);
    ctr_rco = 1'b0;
    n_cmp++;
    if ({done, ctr_enable} !== 2'b10) begin
      n_bad++;
      $display("FAIL rco_next_done: got done/en=%b want 10", {done, ctr_enable});
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    drive_cmd(2'b10, 4'h9, 8'd5);
    cyc(1);
    sb.push_back({2'b10, 4'h9});
    cmd_valid = 1'b0;
    cyc(1);
    if (sb.size() != 0) exp_cmd = sb.pop_front(); else exp_cmd = 'x;
    n_cmp++;
    if ({ctr_mode, ctr_D} !== exp_cmd) begin
      n_bad++;
      $display("FAIL mid_issue: got %h want %h", {ctr_mode, ctr_D}, exp_cmd);
    end
    cyc(2);
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({ctr_enable, ctr_mode, ctr_D, done, err, busy, cmd_ready} !== 11'b0_00_0000_0001) begin
      n_bad++;
      $display("FAIL mid_async_reset: got %b want %b", {ctr_enable, ctr_mode, ctr_D, done, err, busy, cmd_ready}, 11'b0_00_0000_0001);
    end
    cyc(3);
    reset = 1'b1;
    ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      if (done !== 1'b0 || ctr_enable !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL mid_no_done_after: got activity after reset release want none");
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_count();
    test_back_to_back();
    test_timeout();
    test_rco_issue();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
